// File: rtl/constant_encoder.sv
// constant_encoder
//
// Inverse of the immediate extender. Takes a 16-bit constant and a destination
// register. Emits the shortest sequence of immediate-field items that the
// extender turns back into exactly that constant. Each item is a 3-bit
// extend-mode code plus a 12-bit constant field.
//
//   short constant (in_value[15:10] all equal):
//     one item:  loadlit 000, {1'b0, v[10:0]}, last=1
//   long constant:
//     item A:    lch     010, {4'b0, v[15:8]}, last=0
//     item B:    lcl     001, {4'b0, v[7:0]},  last=1
//
// Optional build macro CONST_ENC_SKIP_ZERO_LOW_EN: when it is defined and a
// long constant has a zero low byte, only item A is emitted, with last=1.
// lch on its own already yields {hi, 8'h00}.
//
// Handshakes: a transfer happens on a port when valid && ready are both high
// at a rising clock edge. While valid is high and ready is low, the producer
// holds every payload field stable. It does not retract valid.
//
// Ports:
//   clock, reset          clock; asynchronous active-high reset
//   in_valid / in_ready   request handshake
//   in_value, in_reg      constant to materialise, destination register
//   out_valid / out_ready item handshake
//   out_controle          extend-mode code
//   out_constante         12-bit constant field
//   out_reg               destination register, copied from the request
//   out_last              final item of the sequence
//   busy                  encoder is not idle
//   items_emitted         completed output handshakes, wraps
//   dbg_state             current FSM state encoding (IDLE=0, EMIT_A=1, EMIT_B=2)
module constant_encoder #(
  parameter int REG_W = 3,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_value,
  input  logic [REG_W-1:0] in_reg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_controle,
  output logic [11:0]      out_constante,
  output logic [REG_W-1:0] out_reg,
  output logic             out_last,
  output logic             busy,
  output logic [CNT_W-1:0] items_emitted,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EMIT_A = 2'd1,
    EMIT_B = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic             valid_d, last_d;
  logic [2:0]       ctl_d;
  logic [11:0]      const_d;
  logic [REG_W-1:0] reg_d;
  logic [7:0]       lo_q, lo_d;

  logic handshake, accept;
  logic is_short, skip_low;
  logic [2:0]  first_ctl;
  logic [11:0] first_const;
  logic        first_last;

  assign handshake = out_valid && out_ready;
  assign in_ready  = (state_q == IDLE) || (handshake && out_last);
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

  // Sign-extendable from 11 bits: bits 15..10 all ones or all zeros.
  assign is_short = (&in_value[15:10]) || (~|in_value[15:10]);

`ifdef CONST_ENC_SKIP_ZERO_LOW_EN
  assign skip_low = (in_value[7:0] == 8'h00);
`else
  assign skip_low = 1'b0;
`endif

  // First item of a new sequence, built directly from the request.
  always_comb begin
    first_ctl   = 3'b000;
    first_const = 12'h000;
    first_last  = 1'b1;
    if (is_short) begin
      first_ctl   = 3'b000;
      first_const = {1'b0, in_value[10:0]};
      first_last  = 1'b1;
    end else begin
      first_ctl   = 3'b010;
      first_const = {4'b0000, in_value[15:8]};
      first_last  = skip_low;
    end
  end

  // Next-state and next-output logic. All item fields are registered, and
  // they change only on an accept or an output handshake. This keeps them
  // stable under backpressure.
  always_comb begin
    state_d = state_q;
    valid_d = out_valid;
    last_d  = out_last;
    ctl_d   = out_controle;
    const_d = out_constante;
    reg_d   = out_reg;
    lo_d    = lo_q;

    // A final-item handshake and a new accept can happen in the same cycle.
    // In that case the new first item is loaded directly, so no bubble cycle
    // appears between sequences.
    if (accept) begin
      state_d = EMIT_A;
      valid_d = 1'b1;
      ctl_d   = first_ctl;
      const_d = first_const;
      last_d  = first_last;
      reg_d   = in_reg;
      lo_d    = in_value[7:0];
    end else begin
      case (state_q)
        IDLE: ;
        EMIT_A: begin
          if (handshake) begin
            if (out_last) begin
              state_d = IDLE;
              valid_d = 1'b0;
            end else begin
              state_d = EMIT_B;
              ctl_d   = 3'b001;
              const_d = {4'b0000, lo_q};
              last_d  = 1'b1;
            end
          end
        end
        EMIT_B: begin
          if (handshake) begin
            state_d = IDLE;
            valid_d = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      out_valid     <= 1'b0;
      out_last      <= 1'b0;
      out_controle  <= 3'b000;
      out_constante <= 12'h000;
      out_reg       <= '0;
      lo_q          <= 8'h00;
      items_emitted <= '0;
    end else begin
      state_q       <= state_d;
      out_valid     <= valid_d;
      out_last      <= last_d;
      out_controle  <= ctl_d;
      out_constante <= const_d;
      out_reg       <= reg_d;
      lo_q          <= lo_d;
      if (handshake) begin
        items_emitted <= items_emitted + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_constant_encoder.sv
module tb_constant_encoder;

  localparam int REG_W = 3;
  localparam int CNT_W = 16;

  logic             clock;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_value;
  logic [REG_W-1:0] in_reg;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       out_controle;
  logic [11:0]      out_constante;
  logic [REG_W-1:0] out_reg;
  logic             out_last;
  logic             busy;
  logic [CNT_W-1:0] items_emitted;
  logic [1:0]       dbg_state;

  int n_total;
  int n_pass;
  logic [CNT_W-1:0] exp_items;

  // {out_valid, out_controle, out_constante, out_reg, out_last}
  logic [19:0] item_obs;
  assign item_obs = {out_valid, out_controle, out_constante, out_reg, out_last};

  constant_encoder #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_value      (in_value),
    .in_reg        (in_reg),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_controle  (out_controle),
    .out_constante (out_constante),
    .out_reg       (out_reg),
    .out_last      (out_last),
    .busy          (busy),
    .items_emitted (items_emitted),
    .dbg_state     (dbg_state)
  );

  // Clock and reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs are driven and outputs are sampled at the falling edge.
  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_value  = 16'h0000;
    in_reg    = '0;
    out_ready = 1'b0;
    exp_items = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0; in_value = 16'h0000; in_reg = '0; out_ready = 1'b0;
    repeat (2) @(negedge clock);
    n_total++;
    if (item_obs !== 20'h0) $display("FAIL reset_outputs got=%h exp=%h", item_obs, 20'h0);
    else n_pass++;
    n_total++;
    if ({busy, items_emitted, dbg_state} !== {1'b0, 16'h0000, 2'd0})
      $display("FAIL reset_state busy=%b items=%0d state=%0d exp 0/0/0", busy, items_emitted, dbg_state);
    else n_pass++;
    reset = 1'b0;
    exp_items = '0;
    @(negedge clock);
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    else n_pass++;
  endtask

  task automatic test_short();
    out_ready = 1'b1;
    in_valid = 1'b1; in_value = 16'h0005; in_reg = 3'd2;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL short_in_ready got=%b exp=1", in_ready);
    else n_pass++;
    @(negedge clock);
    in_valid = 1'b0;
    n_total++;
    if (item_obs !== {1'b1, 3'b000, 12'h005, 3'd2, 1'b1})
      $display("FAIL short_item got=%h exp=%h", item_obs, {1'b1, 3'b000, 12'h005, 3'd2, 1'b1});
    else n_pass++;
    @(negedge clock);
    exp_items = exp_items + 1'b1;
    n_total++;
    if ({out_valid, busy, items_emitted} !== {1'b0, 1'b0, exp_items})
      $display("FAIL short_done valid=%b busy=%b items=%0d exp 0/0/%0d", out_valid, busy, items_emitted, exp_items);
    else n_pass++;
  endtask

  task automatic test_boundaries();
    logic [15:0] vals [2];
    logic [11:0] consts [2];
    vals[0] = 16'hFC00; consts[0] = 12'h400;
    vals[1] = 16'h03FF; consts[1] = 12'h3FF;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_value = vals[i]; in_reg = 3'd4;
      @(negedge clock);
      in_valid = 1'b0;
      n_total++;
      if (item_obs !== {1'b1, 3'b000, consts[i], 3'd4, 1'b1})
        $display("FAIL boundary_short_%h got=%h exp=%h", vals[i], item_obs, {1'b1, 3'b000, consts[i], 3'd4, 1'b1});
      else n_pass++;
      @(negedge clock);
      exp_items = exp_items + 1'b1;
    end
    // 0x0400 is the smallest value that needs the long form.
    in_valid = 1'b1; in_value = 16'h0400; in_reg = 3'd6;
    @(negedge clock);
    in_valid = 1'b0;
`ifdef CONST_ENC_SKIP_ZERO_LOW_EN
    n_total++;
    if (item_obs !== {1'b1, 3'b010, 12'h004, 3'd6, 1'b1})
      $display("FAIL boundary_0400_a got=%h exp=%h", item_obs, {1'b1, 3'b010, 12'h004, 3'd6, 1'b1});
    else n_pass++;
    @(negedge clock);
    exp_items = exp_items + 1'b1;
`else
    n_total++;
    if (item_obs !== {1'b1, 3'b010, 12'h004, 3'd6, 1'b0})
      $display("FAIL boundary_0400_a got=%h exp=%h", item_obs, {1'b1, 3'b010, 12'h004, 3'd6, 1'b0});
    else n_pass++;
    @(negedge clock);
    n_total++;
    if (item_obs !== {1'b1, 3'b001, 12'h000, 3'd6, 1'b1})
      $display("FAIL boundary_0400_b got=%h exp=%h", item_obs, {1'b1, 3'b001, 12'h000, 3'd6, 1'b1});
    else n_pass++;
    @(negedge clock);
    exp_items = exp_items + 2'd2;
`endif
    n_total++;
    if ({out_valid, items_emitted} !== {1'b0, exp_items})
      $display("FAIL boundary_count valid=%b items=%0d exp 0/%0d", out_valid, items_emitted, exp_items);
    else n_pass++;
  endtask

  task automatic test_long();
    out_ready = 1'b1;
    in_valid = 1'b1; in_value = 16'h1234; in_reg = 3'd5;
    @(negedge clock);
    // The request is no longer valid and its value changes. Item B must
    // still carry the low byte that was captured at accept.
    in_valid = 1'b0; in_value = 16'hFFFF; in_reg = 3'd0;
    n_total++;
    if (item_obs !== {1'b1, 3'b010, 12'h012, 3'd5, 1'b0})
      $display("FAIL long_a got=%h exp=%h", item_obs, {1'b1, 3'b010, 12'h012, 3'd5, 1'b0});
    else n_pass++;
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL long_in_ready_mid got=%b exp=0", in_ready);
    else n_pass++;
    @(negedge clock);
    n_total++;
    if (item_obs !== {1'b1, 3'b001, 12'h034, 3'd5, 1'b1})
      $display("FAIL long_b got=%h exp=%h", item_obs, {1'b1, 3'b001, 12'h034, 3'd5, 1'b1});
    else n_pass++;
    @(negedge clock);
    exp_items = exp_items + 2'd2;
    n_total++;
    if ({out_valid, busy, items_emitted} !== {1'b0, 1'b0, exp_items})
      $display("FAIL long_done valid=%b busy=%b items=%0d exp 0/0/%0d", out_valid, busy, items_emitted, exp_items);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_value = 16'hABCD; in_reg = 3'd1;
    @(negedge clock);
    in_valid = 1'b0; in_value = 16'h5555;
    for (int c = 0; c < 3; c++) begin
      n_total++;
      if (item_obs !== {1'b1, 3'b010, 12'h0AB, 3'd1, 1'b0})
        $display("FAIL stall_a_cycle%0d got=%h exp=%h", c, item_obs, {1'b1, 3'b010, 12'h0AB, 3'd1, 1'b0});
      else n_pass++;
      if (c == 2) out_ready = 1'b1;
      @(negedge clock);
    end
    n_total++;
    if (item_obs !== {1'b1, 3'b001, 12'h0CD, 3'd1, 1'b1})
      $display("FAIL stall_b got=%h exp=%h", item_obs, {1'b1, 3'b001, 12'h0CD, 3'd1, 1'b1});
    else n_pass++;
    @(negedge clock);
    exp_items = exp_items + 2'd2;
    n_total++;
    if ({out_valid, items_emitted} !== {1'b0, exp_items})
      $display("FAIL stall_done valid=%b items=%0d exp 0/%0d", out_valid, items_emitted, exp_items);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_value = 16'h1234; in_reg = 3'd5;
    @(negedge clock);
    n_total++;
    if (item_obs !== {1'b1, 3'b010, 12'h012, 3'd5, 1'b0})
      $display("FAIL b2b_a got=%h exp=%h", item_obs, {1'b1, 3'b010, 12'h012, 3'd5, 1'b0});
    else n_pass++;
    in_value = 16'h0001; in_reg = 3'd3;   // second request waits for B
    @(negedge clock);
    n_total++;
    if (item_obs !== {1'b1, 3'b001, 12'h034, 3'd5, 1'b1})
      $display("FAIL b2b_b got=%h exp=%h", item_obs, {1'b1, 3'b001, 12'h034, 3'd5, 1'b1});
    else n_pass++;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL b2b_in_ready_at_b got=%b exp=1", in_ready);
    else n_pass++;
    @(negedge clock);
    in_valid = 1'b0;
    n_total++;
    if (item_obs !== {1'b1, 3'b000, 12'h001, 3'd3, 1'b1})
      $display("FAIL b2b_second got=%h exp=%h", item_obs, {1'b1, 3'b000, 12'h001, 3'd3, 1'b1});
    else n_pass++;
    @(negedge clock);
    exp_items = 16'd3;
    n_total++;
    if ({out_valid, busy, items_emitted} !== {1'b0, 1'b0, exp_items})
      $display("FAIL b2b_done valid=%b busy=%b items=%0d exp 0/0/%0d", out_valid, busy, items_emitted, exp_items);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_value = 16'hABCD; in_reg = 3'd2;
    @(negedge clock);
    in_valid = 1'b0;
    n_total++;
    if (item_obs !== {1'b1, 3'b010, 12'h0AB, 3'd2, 1'b0})
      $display("FAIL midreset_a got=%h exp=%h", item_obs, {1'b1, 3'b010, 12'h0AB, 3'd2, 1'b0});
    else n_pass++;
    #2 reset = 1'b1;
    #1;
    exp_items = '0;
    n_total++;
    if ({item_obs, busy, items_emitted} !== {20'h0, 1'b0, exp_items})
      $display("FAIL midreset_clear item=%h busy=%b items=%0d exp 0/0/0", item_obs, busy, items_emitted);
    else n_pass++;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    n_total++;
    if ({out_valid, busy, items_emitted} !== {1'b0, 1'b0, exp_items})
      $display("FAIL midreset_after valid=%b busy=%b items=%0d exp 0/0/0", out_valid, busy, items_emitted);
    else n_pass++;
  endtask

  task automatic test_zero_low();
    out_ready = 1'b1;
    in_valid = 1'b1; in_value = 16'h1200; in_reg = 3'd7;
    @(negedge clock);
    in_valid = 1'b0;
`ifdef CONST_ENC_SKIP_ZERO_LOW_EN
    n_total++;
    if (item_obs !== {1'b1, 3'b010, 12'h012, 3'd7, 1'b1})
      $display("FAIL zero_low_a got=%h exp=%h", item_obs, {1'b1, 3'b010, 12'h012, 3'd7, 1'b1});
    else n_pass++;
    @(negedge clock);
    exp_items = exp_items + 1'b1;
`else
    n_total++;
    if (item_obs !== {1'b1, 3'b010, 12'h012, 3'd7, 1'b0})
      $display("FAIL zero_low_a got=%h exp=%h", item_obs, {1'b1, 3'b010, 12'h012, 3'd7, 1'b0});
    else n_pass++;
    @(negedge clock);
    n_total++;
    if (item_obs !== {1'b1, 3'b001, 12'h000, 3'd7, 1'b1})
      $display("FAIL zero_low_b got=%h exp=%h", item_obs, {1'b1, 3'b001, 12'h000, 3'd7, 1'b1});
    else n_pass++;
    @(negedge clock);
    exp_items = exp_items + 2'd2;
`endif
    n_total++;
    if ({out_valid, items_emitted} !== {1'b0, exp_items})
      $display("FAIL zero_low_done valid=%b items=%0d exp 0/%0d", out_valid, items_emitted, exp_items);
    else n_pass++;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    exp_items = '0;
    reset = 1'b1;
    in_valid = 1'b0; in_value = 16'h0000; in_reg = '0; out_ready = 1'b0;
    test_reset();
    test_short();
    test_boundaries();
    test_long();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_zero_low();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
